ysyx_220066_trapctl: RTL and testbench

Trap initiator for the ysyx_220066 core. It watches the commit stage and a built-in machine timer (CLINT-lite: mtime/mtimecmp), and picks one event per instruction boundary: illegal instruction, ecall, mret or timer interrupt. It drives the CSR file's trap inputs (`raise_intr`, `NO`, `pc`, `ret`) as registered one-cycle pulses, kills and stalls the commit stage, and holds the pipeline while the redirect settles.

---
 rtl/ysyx_220066_pkg.sv | 22 ++
 rtl/ysyx_220066_trapctl_if.sv | 35 +++
 rtl/ysyx_220066_clint.sv | 69 ++++++
 rtl/ysyx_220066_trapctl.sv | 144 ++++++++++++++
 tb/tb_ysyx_220066_trapctl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_220066_pkg.sv
// Shared constants and types for the ysyx_220066 trap controller and its CLINT-lite timer.
package ysyx_220066_pkg;

    localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

    localparam logic [63:0] CLINT_MTIME_ADDR    = 64'h0000_0000_0200_bff8;
    localparam logic [63:0] CLINT_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_DRAIN = 2'd2
    } trap_state_e;

    // Unsigned timer compare: the interrupt is pending once mtime catches up with mtimecmp.
    function automatic logic timer_pending(input logic [63:0] mtime, input logic [63:0] mtimecmp);
        return (mtime >= mtimecmp);
    endfunction

endpackage

// File: rtl/ysyx_220066_trapctl_if.sv
// Commit-stage, CSR trap and CLINT bus signals shared between the trap controller and its environment.
interface ysyx_220066_trapctl_if;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        commit_ecall;
    logic        commit_mret;
    logic        commit_illegal;
    logic        mstatus_mie;
    logic        bus_wen;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_hit;
    logic        commit_ready;
    logic        commit_kill;
    logic        raise_intr;
    logic [63:0] NO;
    logic [63:0] pc;
    logic        ret;
    logic        flush;

    modport master (
        output commit_valid, commit_pc, commit_ecall, commit_mret, commit_illegal,
        output mstatus_mie, bus_wen, bus_addr, bus_wdata,
        input  bus_rdata, bus_hit, commit_ready, commit_kill,
        input  raise_intr, NO, pc, ret, flush
    );

    modport slave (
        input  commit_valid, commit_pc, commit_ecall, commit_mret, commit_illegal,
        input  mstatus_mie, bus_wen, bus_addr, bus_wdata,
        output bus_rdata, bus_hit, commit_ready, commit_kill,
        output raise_intr, NO, pc, ret, flush
    );
endinterface

// File: rtl/ysyx_220066_clint.sv
// CLINT-lite: prescaled 64-bit mtime, mtimecmp, bus decode and the machine timer pending level.
module ysyx_220066_clint
    import ysyx_220066_pkg::*;
#(
    parameter int          TICK_DIV      = 1,
    parameter logic [63:0] MTIME_ADDR    = CLINT_MTIME_ADDR,
    parameter logic [63:0] MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bus_wen,
    input  logic [63:0] i_bus_addr,
    input  logic [63:0] i_bus_wdata,
    output logic [63:0] o_bus_rdata,
    output logic        o_bus_hit,
    output logic        o_mtip
);

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    logic [7:0]  r_prescale;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        w_sel_mtime;
    logic        w_sel_cmp;
    logic        w_wrap;
    logic [63:0] w_rdata;

    // Address decode and combinational read mux.
    always_comb begin
        w_sel_mtime = (i_bus_addr == MTIME_ADDR);
        w_sel_cmp   = (i_bus_addr == MTIMECMP_ADDR);
        w_wrap      = (r_prescale == TICK_LAST);
        if (w_sel_mtime) begin
            w_rdata = r_mtime;
        end else if (w_sel_cmp) begin
            w_rdata = r_mtimecmp;
        end else begin
            w_rdata = 64'd0;
        end
    end

    // Prescaler, mtime and mtimecmp; a bus write to mtime wins over that cycle's tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= 8'd0;
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (i_bus_wen && w_sel_mtime) begin
                r_mtime    <= i_bus_wdata;
                r_prescale <= 8'd0;
            end else if (w_wrap) begin
                r_mtime    <= r_mtime + 64'd1;
                r_prescale <= 8'd0;
            end else begin
                r_prescale <= r_prescale + 8'd1;
            end
            if (i_bus_wen && w_sel_cmp) begin
                r_mtimecmp <= i_bus_wdata;
            end
        end
    end

    assign o_bus_rdata = w_rdata;
    assign o_bus_hit   = w_sel_mtime | w_sel_cmp;
    assign o_mtip      = timer_pending(r_mtime, r_mtimecmp);

endmodule

// File: rtl/ysyx_220066_trapctl.sv
// Trap initiator: picks one event per commit boundary, pulses the CSR trap inputs and
// holds the pipeline while the redirect settles.
module ysyx_220066_trapctl
    import ysyx_220066_pkg::*;
#(
    parameter int          DRAIN_CYCLES  = 2,
    parameter int          TICK_DIV      = 1,
    parameter logic [63:0] MTIME_ADDR    = CLINT_MTIME_ADDR,
    parameter logic [63:0] MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_220066_trapctl_if.slave    io_trap
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    trap_state_e r_state;
    trap_state_e w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [63:0] r_no;
    logic [63:0] r_pc;
    logic        r_raise;
    logic        r_ret;
    logic        r_flush;
    logic        w_take;
    logic        w_is_ret;
    logic [63:0] w_no_nxt;
    logic        w_kill;
    logic        w_ready;
    logic        w_raise_nxt;
    logic        w_ret_nxt;
    logic        w_flush_nxt;
    logic        w_mtip;

    ysyx_220066_clint #(
        .TICK_DIV      (TICK_DIV),
        .MTIME_ADDR    (MTIME_ADDR),
        .MTIMECMP_ADDR (MTIMECMP_ADDR)
    ) u_clint (
        .clk         (clk),
        .rst         (rst),
        .i_bus_wen   (io_trap.bus_wen),
        .i_bus_addr  (io_trap.bus_addr),
        .i_bus_wdata (io_trap.bus_wdata),
        .o_bus_rdata (io_trap.bus_rdata),
        .o_bus_hit   (io_trap.bus_hit),
        .o_mtip      (w_mtip)
    );

    // Event selection (illegal > ecall > mret > timer) and FIRE/DRAIN sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_is_ret    = 1'b0;
        w_no_nxt    = r_no;
        w_kill      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (io_trap.commit_valid) begin
                    if (io_trap.commit_illegal) begin
                        w_take   = 1'b1;
                        w_no_nxt = CAUSE_ILLEGAL;
                    end else if (io_trap.commit_ecall) begin
                        w_take   = 1'b1;
                        w_no_nxt = CAUSE_ECALL_M;
                    end else if (io_trap.commit_mret) begin
                        w_take   = 1'b1;
                        w_is_ret = 1'b1;
                    end else if (io_trap.mstatus_mie && w_mtip) begin
                        w_take   = 1'b1;
                        w_no_nxt = CAUSE_MTI;
                    end else begin
                        w_take   = 1'b0;
                    end
                end else begin
                    w_take = 1'b0;
                end
                w_kill = w_take & ~w_is_ret;
                if (w_take) begin
                    w_state_nxt = ST_FIRE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FIRE: begin
                w_state_nxt = ST_DRAIN;
                w_cnt_nxt   = DRAIN_LOAD;
            end
            ST_DRAIN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (w_cnt_nxt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        // Pulses are registered so they line up with the FIRE state itself.
        w_raise_nxt = (w_state_nxt == ST_FIRE) & ~w_is_ret;
        w_ret_nxt   = (w_state_nxt == ST_FIRE) & w_is_ret;
        w_flush_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, drain counter, latched cause/pc and registered CSR pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_no    <= 64'd0;
            r_pc    <= 64'd0;
            r_raise <= 1'b0;
            r_ret   <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_raise <= w_raise_nxt;
            r_ret   <= w_ret_nxt;
            r_flush <= w_flush_nxt;
            if (w_take) begin
                r_no <= w_no_nxt;
                r_pc <= io_trap.commit_pc;
            end
        end
    end

    assign io_trap.commit_ready = w_ready;
    assign io_trap.commit_kill  = w_kill;
    assign io_trap.raise_intr   = r_raise;
    assign io_trap.ret          = r_ret;
    assign io_trap.flush        = r_flush;
    assign io_trap.NO           = r_no;
    assign io_trap.pc           = r_pc;

endmodule

// File: tb/tb_ysyx_220066_trapctl.sv
// Directed self-checking bench for ysyx_220066_trapctl (DRAIN_CYCLES=2, TICK_DIV=1).
module tb_ysyx_220066_trapctl;

    localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_bff8;
    localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
    localparam logic [63:0] MTI     = 64'h8000_0000_0000_0007;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ysyx_220066_trapctl_if tif ();

    ysyx_220066_trapctl #(
        .DRAIN_CYCLES  (2),
        .TICK_DIV      (1),
        .MTIME_ADDR    (A_MTIME),
        .MTIMECMP_ADDR (A_CMP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_trap (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tif.commit_valid   = 1'b0;
        tif.commit_pc      = 64'd0;
        tif.commit_ecall   = 1'b0;
        tif.commit_mret    = 1'b0;
        tif.commit_illegal = 1'b0;
        tif.bus_wen        = 1'b0;
        tif.bus_addr       = 64'd0;
        tif.bus_wdata      = 64'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tif.mstatus_mie = 1'b0;
        tick();
        tick();
        checks++; if (tif.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", tif.commit_ready); end
        checks++; if ({tif.raise_intr, tif.ret, tif.flush, tif.commit_kill, tif.bus_hit} !== 5'b00000) begin errors++; $display("FAIL reset_outs got=%b want=00000", {tif.raise_intr, tif.ret, tif.flush, tif.commit_kill, tif.bus_hit}); end
        checks++; if ({tif.NO, tif.pc} !== 128'd0) begin errors++; $display("FAIL reset_no_pc got NO=%h pc=%h want 0", tif.NO, tif.pc); end
        tif.bus_addr = A_CMP;
        #1;
        checks++; if (tif.bus_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_mtimecmp got=%h want=ffffffffffffffff", tif.bus_rdata); end
        tif.bus_addr = A_MTIME;
        #1;
        checks++; if (tif.bus_rdata !== 64'd0) begin errors++; $display("FAIL reset_mtime got=%h want=0", tif.bus_rdata); end
        tif.bus_addr = 64'd0;
        rst = 1'b0;
        tick();
    endtask

    // Drain check shared shape: 2 more flush cycles then ready again.
    task automatic test_ecall();
        tif.commit_valid = 1'b1; tif.commit_ecall = 1'b1; tif.commit_pc = 64'h8000_0010;
        #1;
        checks++; if (tif.commit_kill !== 1'b1) begin errors++; $display("FAIL ecall_kill got=%b want=1", tif.commit_kill); end
        tick();
        clear_inputs();
        checks++; if ({tif.raise_intr, tif.ret, tif.flush} !== 3'b101) begin errors++; $display("FAIL ecall_pulse got raise/ret/flush=%b want=101", {tif.raise_intr, tif.ret, tif.flush}); end
        checks++; if (tif.NO !== 64'd11) begin errors++; $display("FAIL ecall_no got=%h want=b", tif.NO); end
        checks++; if (tif.pc !== 64'h8000_0010) begin errors++; $display("FAIL ecall_pc got=%h want=80000010", tif.pc); end
        tick();
        checks++; if ({tif.raise_intr, tif.flush, tif.commit_ready} !== 3'b010) begin errors++; $display("FAIL ecall_drain1 got raise/flush/ready=%b want=010", {tif.raise_intr, tif.flush, tif.commit_ready}); end
        tick();
        checks++; if ({tif.flush, tif.commit_ready} !== 2'b10) begin errors++; $display("FAIL ecall_drain2 got flush/ready=%b want=10", {tif.flush, tif.commit_ready}); end
        tick();
        checks++; if ({tif.flush, tif.commit_ready} !== 2'b01) begin errors++; $display("FAIL ecall_idle got flush/ready=%b want=01", {tif.flush, tif.commit_ready}); end
        checks++; if (tif.NO !== 64'd11) begin errors++; $display("FAIL ecall_no_hold got=%h want=b", tif.NO); end
    endtask

    task automatic test_ecall_illegal();
        tif.commit_valid = 1'b1; tif.commit_ecall = 1'b1; tif.commit_illegal = 1'b1; tif.commit_pc = 64'h8000_0020;
        #1;
        checks++; if (tif.commit_kill !== 1'b1) begin errors++; $display("FAIL both_kill got=%b want=1", tif.commit_kill); end
        tick();
        clear_inputs();
        checks++; if ({tif.raise_intr, tif.NO, tif.pc} !== {1'b1, 64'd2, 64'h8000_0020}) begin errors++; $display("FAIL both_pulse got raise=%b NO=%h pc=%h want 1/2/80000020", tif.raise_intr, tif.NO, tif.pc); end
        tick();
        checks++; if (tif.raise_intr !== 1'b0) begin errors++; $display("FAIL both_single got=%b want=0", tif.raise_intr); end
        tick();
        tick();
        checks++; if (tif.commit_ready !== 1'b1) begin errors++; $display("FAIL both_ready got=%b want=1", tif.commit_ready); end
    endtask

    task automatic test_mret();
        tif.commit_valid = 1'b1; tif.commit_mret = 1'b1; tif.commit_pc = 64'h8000_0030;
        #1;
        checks++; if (tif.commit_kill !== 1'b0) begin errors++; $display("FAIL mret_kill got=%b want=0", tif.commit_kill); end
        tick();
        clear_inputs();
        checks++; if ({tif.ret, tif.raise_intr, tif.flush} !== 3'b101) begin errors++; $display("FAIL mret_pulse got ret/raise/flush=%b want=101", {tif.ret, tif.raise_intr, tif.flush}); end
        tick();
        checks++; if (tif.ret !== 1'b0) begin errors++; $display("FAIL mret_single got=%b want=0", tif.ret); end
        tick();
        tick();
        checks++; if (tif.commit_ready !== 1'b1) begin errors++; $display("FAIL mret_ready got=%b want=1", tif.commit_ready); end
    endtask

    task automatic test_timer_irq();
        logic [63:0] pcv;
        tif.mstatus_mie = 1'b1;
        tif.bus_wen = 1'b1; tif.bus_addr = A_MTIME; tif.bus_wdata = 64'd0;
        tick();
        tif.bus_addr = A_CMP; tif.bus_wdata = 64'd5;
        tick();
        clear_inputs();
        // mtime is 1 here and reaches 5 on the fifth commit.
        for (int k = 0; k < 5; k++) begin
            pcv = 64'h8000_1000 + 64'(4 * k);
            tif.commit_valid = 1'b1; tif.commit_pc = pcv;
            #1;
            checks++; if (tif.commit_kill !== (k == 4)) begin errors++; $display("FAIL irq_kill_%0d got=%b want=%b", k, tif.commit_kill, (k == 4)); end
            if (k < 4) tick();
        end
        tick();
        clear_inputs();
        checks++; if ({tif.raise_intr, tif.NO, tif.pc} !== {1'b1, MTI, 64'h8000_1010}) begin errors++; $display("FAIL irq_pulse got raise=%b NO=%h pc=%h want 1/%h/80001010", tif.raise_intr, tif.NO, tif.pc, MTI); end
        tick(); tick(); tick();
        #1;
        checks++; if (tif.commit_kill !== 1'b0) begin errors++; $display("FAIL irq_novalid_kill got=%b want=0", tif.commit_kill); end
        tick();
        checks++; if ({tif.raise_intr, tif.commit_ready} !== 2'b01) begin errors++; $display("FAIL irq_novalid_pulse got raise/ready=%b want=01", {tif.raise_intr, tif.commit_ready}); end
        tif.mstatus_mie = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tif.commit_valid = 1'b1; tif.commit_pc = 64'h8000_1100 + 64'(4 * k);
            #1;
            checks++; if ({tif.commit_kill, tif.commit_ready, tif.raise_intr} !== 3'b010) begin errors++; $display("FAIL masked_%0d got kill/ready/raise=%b want=010", k, {tif.commit_kill, tif.commit_ready, tif.raise_intr}); end
            tick();
        end
        clear_inputs();
        tif.mstatus_mie = 1'b1;
        tif.commit_valid = 1'b1; tif.commit_mret = 1'b1; tif.commit_pc = 64'h8000_1200;
        #1;
        checks++; if (tif.commit_kill !== 1'b0) begin errors++; $display("FAIL mret_pend_kill got=%b want=0", tif.commit_kill); end
        tick();
        clear_inputs();
        checks++; if ({tif.ret, tif.raise_intr} !== 2'b10) begin errors++; $display("FAIL mret_pend_pulse got ret/raise=%b want=10", {tif.ret, tif.raise_intr}); end
        tick(); tick(); tick();
        tif.commit_valid = 1'b1; tif.commit_pc = 64'h8000_2000;
        tif.bus_wen = 1'b1; tif.bus_addr = A_CMP; tif.bus_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (tif.commit_kill !== 1'b1) begin errors++; $display("FAIL cmp_samecycle_kill got=%b want=1", tif.commit_kill); end
        tick();
        clear_inputs();
        checks++; if ({tif.raise_intr, tif.NO, tif.pc} !== {1'b1, MTI, 64'h8000_2000}) begin errors++; $display("FAIL cmp_samecycle_pulse got raise=%b NO=%h pc=%h", tif.raise_intr, tif.NO, tif.pc); end
        tick(); tick(); tick();
        tif.commit_valid = 1'b1; tif.commit_pc = 64'h8000_2004;
        #1;
        checks++; if (tif.commit_kill !== 1'b0) begin errors++; $display("FAIL cmp_new_kill got=%b want=0", tif.commit_kill); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mtime_wrap();
        tif.bus_wen = 1'b1; tif.bus_addr = A_MTIME; tif.bus_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        tif.bus_wen = 1'b0;
        #1;
        checks++; if ({tif.bus_rdata, tif.bus_hit} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b1}) begin errors++; $display("FAIL wrap_readback got=%h hit=%b want=fffffffffffffffe/1", tif.bus_rdata, tif.bus_hit); end
        tick();
        tick();
        checks++; if (tif.bus_rdata !== 64'd0) begin errors++; $display("FAIL wrap_zero got=%h want=0", tif.bus_rdata); end
        tif.bus_addr = 64'h0000_0000_0200_0008;
        #1;
        checks++; if ({tif.bus_rdata, tif.bus_hit} !== {64'd0, 1'b0}) begin errors++; $display("FAIL unmapped got=%h hit=%b want=0/0", tif.bus_rdata, tif.bus_hit); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_in_drain();
        tif.commit_valid = 1'b1; tif.commit_illegal = 1'b1; tif.commit_pc = 64'h8000_3000;
        tick();
        clear_inputs();
        tick();
        checks++; if ({tif.flush, tif.commit_ready} !== 2'b10) begin errors++; $display("FAIL rstdrain_pre got flush/ready=%b want=10", {tif.flush, tif.commit_ready}); end
        rst = 1'b1;
        tick();
        tif.bus_addr = A_MTIME;
        #1;
        checks++; if ({tif.flush, tif.commit_ready, tif.raise_intr, tif.ret} !== 4'b0100) begin errors++; $display("FAIL rstdrain_outs got flush/ready/raise/ret=%b want=0100", {tif.flush, tif.commit_ready, tif.raise_intr, tif.ret}); end
        checks++; if (tif.bus_rdata !== 64'd0) begin errors++; $display("FAIL rstdrain_mtime got=%h want=0", tif.bus_rdata); end
        rst = 1'b0;
        tick();
        checks++; if ({tif.raise_intr, tif.ret, tif.flush} !== 3'b000) begin errors++; $display("FAIL rstdrain_after got raise/ret/flush=%b want=000", {tif.raise_intr, tif.ret, tif.flush}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ecall();
        test_ecall_illegal();
        test_mret();
        test_timer_irq();
        test_mtime_wrap();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
